// File: rtl/mod_n_counter.sv
// mod_n_counter
//   Modulo-N up/down counter with synchronous clear and saturating load. It
//   produces a one-cycle wrap pulse and a divided output that toggles on
//   every wrap.
//
// Parameters
//   WIDTH    counter width in bits
//   MODULUS  count range 0..MODULUS-1, with 2 <= MODULUS <= 2**WIDTH
//
// Ports
//   clock     in   single clock; all state updates on its rising edge
//   rst       in   asynchronous reset, active low
//   enable    in   step one position per clock when 1
//   up        in   step direction (1 = increment, 0 = decrement)
//   clear     in   synchronous clear (highest priority)
//   load      in   synchronous load of load_val, saturated to MODULUS-1
//   load_val  in   value to load
//   count     out  current count, registered
//   wrap_p    out  registered one-cycle pulse following a wrap edge
//   div_out   out  registered divided output, toggles on every wrap
module mod_n_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap_p,
  output logic             div_out
);

  generate
    if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_check
      $error("mod_n_counter: illegal parameters WIDTH=%0d MODULUS=%0d", WIDTH, MODULUS);
    end
  endgenerate

  // One extra bit so that MODULUS == 2**WIDTH is representable in comparisons.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_div;

  logic             w_legal;
  logic             w_at_top;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_sat;

  assign w_legal    = ({1'b0, r_count} < MOD_EXT);
  assign w_at_top   = (r_count == MAX_CNT);
  assign w_at_zero  = (r_count == '0);
  assign w_load_sat = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_CNT;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_div   <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_div   <= 1'b0;
    end else if (load) begin
      r_count <= w_load_sat;
      r_wrap  <= 1'b0;
    end else if (enable) begin
      if (!w_legal) begin
        // An out-of-range count recovers to 0 silently; this is not a wrap.
        r_count <= '0;
        r_wrap  <= 1'b0;
      end else if (up) begin
        if (w_at_top) begin
          r_count <= '0;
          r_wrap  <= 1'b1;
          r_div   <= ~r_div;
        end else begin
          r_count <= r_count + 1'b1;
          r_wrap  <= 1'b0;
        end
      end else begin
        if (w_at_zero) begin
          r_count <= MAX_CNT;
          r_wrap  <= 1'b1;
          r_div   <= ~r_div;
        end else begin
          r_count <= r_count - 1'b1;
          r_wrap  <= 1'b0;
        end
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign count   = r_count;
  assign wrap_p  = r_wrap;
  assign div_out = r_div;

endmodule

// File: tb/tb_mod_n_counter.sv
module tb_mod_n_counter;

  logic       clock = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       up = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] count6, count8;
  logic       wrap6, wrap8, div6, div8;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  mod_n_counter #(.WIDTH(3), .MODULUS(6)) dut (
    .clock(clock), .rst(rst), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_val(load_val), .count(count6), .wrap_p(wrap6), .div_out(div6)
  );

  mod_n_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clock(clock), .rst(rst), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_val(load_val), .count(count8), .wrap_p(wrap8), .div_out(div8)
  );

  // Stoppable clock: toggles every 5 time units while clk_run is set.
  always begin
    #5;
    if (clk_run) clock = ~clock;
  end

  // Behavioural model: index 0 is MODULUS=6, index 1 is MODULUS=8.
  int mods [2] = '{6, 8};
  int m_cnt [2];
  int m_wrap[2];
  int m_div [2];

  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_wrap[k] = 0; m_div[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int s;
        if (clear) begin
          m_cnt[k] = 0; m_wrap[k] = 0; m_div[k] = 0;
        end else if (load) begin
          m_cnt[k]  = (int'(load_val) < mods[k]) ? int'(load_val) : mods[k] - 1;
          m_wrap[k] = 0;
        end else if (enable) begin
          // Unbounded step; leaving the range 0..M-1 is exactly a wrap.
          s = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
          m_wrap[k] = (s < 0 || s >= mods[k]) ? 1 : 0;
          m_cnt[k]  = (s + mods[k]) % mods[k];
          m_div[k]  = m_div[k] ^ m_wrap[k];
        end else begin
          m_wrap[k] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Hand-computed literal: pins both the DUT and the model.
  task automatic pin(input string name, input int act_dut, input int act_mod, input int exp);
    chk({name, "_dut"}, act_dut, exp);
    chk({name, "_model"}, act_mod, exp);
  endtask

  always @(negedge clock) begin
    if (cmp_en && rst) begin
      chk("cyc_count6", int'(count6), m_cnt[0]);
      chk("cyc_wrap6",  int'(wrap6),  m_wrap[0]);
      chk("cyc_div6",   int'(div6),   m_div[0]);
      chk("cyc_count8", int'(count8), m_cnt[1]);
      chk("cyc_wrap8",  int'(wrap8),  m_wrap[1]);
      chk("cyc_div8",   int'(div8),   m_div[1]);
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  int exp_c[13] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1};
  int exp_w[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
  int exp_d[13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
  bit up_pat[8] = '{1, 0, 0, 0, 1, 1, 0, 1};

  initial begin
    #3;
    pin("rst_count", int'(count6), m_cnt[0], 0);
    pin("rst_wrap",  int'(wrap6),  m_wrap[0], 0);
    pin("rst_div",   int'(div6),   m_div[0], 0);
    #9;
    rst = 1'b1;
    cmp_en = 1'b1;

    // Continuous up count through two wraps.
    enable = 1'b1; up = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      pin($sformatf("up13_count_e%0d", i + 1), int'(count6), m_cnt[0], exp_c[i]);
      pin($sformatf("up13_wrap_e%0d",  i + 1), int'(wrap6),  m_wrap[0], exp_w[i]);
      pin($sformatf("up13_div_e%0d",   i + 1), int'(div6),   m_div[0], exp_d[i]);
    end

    // Down wrap from 0.
    enable = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0; enable = 1'b1; up = 1'b0;
    step();
    pin("down_wrap_count", int'(count6), m_cnt[0], 5);
    pin("down_wrap_wrap",  int'(wrap6),  m_wrap[0], 1);
    pin("down_wrap_div",   int'(div6),   m_div[0], 1);
    step();
    pin("down_next_count", int'(count6), m_cnt[0], 4);
    pin("down_next_wrap",  int'(wrap6),  m_wrap[0], 0);

    // Saturating load, then load winning over enable.
    enable = 1'b0; load = 1'b1; load_val = 3'd7;
    step();
    pin("load_sat_count", int'(count6), m_cnt[0], 5);
    pin("load_sat_div",   int'(div6),   m_div[0], 1);
    chk("load7_count8", int'(count8), 7);
    load_val = 3'd3; enable = 1'b1; up = 1'b1;
    step();
    pin("load_win_count", int'(count6), m_cnt[0], 3);
    pin("load_win_div",   int'(div6),   m_div[0], 1);

    // Clear beats load and enable.
    load_val = 3'd5; enable = 1'b0;
    step();
    clear = 1'b1; load = 1'b1; enable = 1'b1; up = 1'b1;
    step();
    pin("clear_pri_count", int'(count6), m_cnt[0], 0);
    pin("clear_pri_div",   int'(div6),   m_div[0], 0);
    pin("clear_pri_wrap",  int'(wrap6),  m_wrap[0], 0);

    // Direction changing every cycle, then hold.
    clear = 1'b0; load = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      up = up_pat[i];
      step();
    end
    enable = 1'b0;
    step();
    step();

    // Async reset with clock stopped at count=4, div_out=1.
    clear = 1'b1;
    step();
    clear = 1'b0; enable = 1'b1; up = 1'b1;
    for (int i = 0; i < 10; i++) step();
    enable = 1'b0;
    @(negedge clock);
    clk_run = 1'b0;
    #1;
    pin("stop_count", int'(count6), m_cnt[0], 4);
    pin("stop_div",   int'(div6),   m_div[0], 1);
    rst = 1'b0;
    #3;
    pin("async_count", int'(count6), m_cnt[0], 0);
    pin("async_div",   int'(div6),   m_div[0], 0);
    pin("async_wrap",  int'(wrap6),  m_wrap[0], 0);
    chk("async_count8", int'(count8), 0);
    rst = 1'b1;
    #3;
    enable = 1'b1; up = 1'b1;
    clk_run = 1'b1;
    step();
    pin("release_count", int'(count6), m_cnt[0], 1);

    // Reset pulse while sitting on a wrap edge: no pulse afterwards.
    enable = 1'b0; load = 1'b1; load_val = 3'd5;
    step();
    load = 1'b0; enable = 1'b1; up = 1'b1;
    @(negedge clock);
    #1;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    step();
    pin("rst_wrapedge_count", int'(count6), m_cnt[0], 1);
    pin("rst_wrapedge_wrap",  int'(wrap6),  m_wrap[0], 0);

    // Full-range MODULUS=8: natural rollover both directions.
    enable = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0; load = 1'b1; load_val = 3'd7;
    step();
    load = 1'b0; enable = 1'b1; up = 1'b1;
    step();
    pin("m8_up_count", int'(count8), m_cnt[1], 0);
    pin("m8_up_wrap",  int'(wrap8),  m_wrap[1], 1);
    pin("m8_up_div",   int'(div8),   m_div[1], 1);
    up = 1'b0;
    step();
    pin("m8_dn_count", int'(count8), m_cnt[1], 7);
    pin("m8_dn_wrap",  int'(wrap8),  m_wrap[1], 1);
    pin("m8_dn_div",   int'(div8),   m_div[1], 0);
    enable = 1'b0;
    step();
    step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_n_counter.md
MOD_N_COUNTER -- requirements
Module: mod_n_counter

Interface
- REQ-001: Parameter WIDTH, default 3, counter width in bits.
- REQ-002: Parameter MODULUS, default 6, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2^WIDTH.
- REQ-003: clock  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: rst  input  1  asynchronous, active-low reset (asserted when 0).
- REQ-005: enable  input  1  when 1, counter SHALL step one position per clock.
- REQ-006: up  input  1  direction; 1 = increment, 0 = decrement.
- REQ-007: clear  input  1  synchronous clear to 0.
- REQ-008: load  input  1  synchronous load of load_val.
- REQ-009: load_val  input  WIDTH  value to load.
- REQ-010: count  output  WIDTH  current count, registered.
- REQ-011: wrap_p  output  1  one-cycle pulse, registered, marking a wrap.
- REQ-012: div_out  output  1  registered divided output, toggles on every wrap.

Function
- REQ-013: Per-edge priority SHALL be clear > load > enable > hold.
- REQ-014: clear=1: count <= 0, div_out <= 0, wrap_p <= 0, regardless of load/enable/up.
- REQ-015: load=1 (clear=0): count <= load_val if load_val < MODULUS, else MODULUS-1 (saturate); div_out unchanged; wrap_p <= 0.
- REQ-016: enable=1, up=1: count==MODULUS-1 -> 0 (wrap); otherwise count+1.
- REQ-017: enable=1, up=0: count==0 -> MODULUS-1 (wrap); otherwise count-1.
- REQ-018: On a wrap edge, div_out SHALL toggle and wrap_p SHALL be 1 for exactly the following cycle.
- REQ-019: On every non-wrap edge, wrap_p SHALL be 0 and div_out SHALL hold.
- REQ-020: enable=0 with clear=0, load=0: count and div_out hold; wrap_p <= 0.
- REQ-021: With enable held 1, constant direction, wrap_p period SHALL be MODULUS clocks and div_out period 2*MODULUS clocks.
- REQ-022: up may change on any cycle; the step SHALL use the value of up sampled at that edge, with no added latency.
- REQ-023: If count >= MODULUS (illegal), the next enabled step SHALL go to 0 with no wrap asserted; clear or load SHALL also recover.
- REQ-024: When MODULUS == 2^WIDTH, wrap SHALL be natural rollover (2^WIDTH-1 -> 0 up, 0 -> 2^WIDTH-1 down) with identical wrap_p/div_out behaviour.
- REQ-025: No internal or derived signal SHALL be used as a clock or as an asynchronous reset; rst is the only asynchronous input.
- REQ-026: Illegal parameter combinations SHALL be flagged at elaboration.

Reset
- REQ-027: While rst=0, count=0, wrap_p=0, div_out=0 immediately, independent of clock.
- REQ-028: The first edge after rst rises SHALL act per Function on the inputs then present; no extra dead cycle.
- REQ-029: Reset asserted mid-count or on a wrap edge SHALL override; no wrap_p pulse after release.

Verification (WIDTH=3, MODULUS=6 unless noted)
- REQ-030: Reset, then enable=1, up=1 for 13 edges -> count 1,2,3,4,5,0,1,...,0,1; wrap_p=1 only after edges 6 and 12; div_out 1 after edge 6, 0 after edge 12.
- REQ-031: From count=0, enable=1, up=0 for 1 edge -> count=5, wrap_p=1, div_out toggles; next edge -> count=4, wrap_p=0.
- REQ-032: load=1, load_val=7 -> count=5; load=1, load_val=3, enable=1 -> count=3 (load wins); div_out unchanged in both.
- REQ-033: count=5, div_out=1, clear=1, load=1, enable=1, up=1 -> count=0, div_out=0, wrap_p=0 next cycle.
- REQ-034: Clock stopped at count=4, div_out=1, rst driven 0 -> count=0, div_out=0, wrap_p=0 without any edge; release, enable -> count=1.
- REQ-035: WIDTH=3, MODULUS=8, enable=1, up=1 from 7 -> count=0, wrap_p=1; up=0 from 0 -> count=7, wrap_p=1.
